// File: rtl/sirv_qspi_flash_fetch.sv
// ICB-to-flashmap fetch engine: turns one aligned ICB read into a run of
// single-byte address/data handshakes and assembles a little-endian response.
module sirv_qspi_flash_fetch #(
  parameter logic [31:0] FLASH_ADDR_MASK = 32'h1FFF_FFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_icb_cmd_valid,
  output logic        i_icb_cmd_ready,
  input  logic [31:0] i_icb_cmd_addr,
  input  logic        i_icb_cmd_read,
  input  logic [1:0]  i_icb_cmd_size,
  output logic        i_icb_rsp_valid,
  input  logic        i_icb_rsp_ready,
  output logic [31:0] i_icb_rsp_rdata,
  output logic        i_icb_rsp_err,
  output logic        o_addr_valid,
  input  logic        o_addr_ready,
  output logic [31:0] o_addr_next,
  output logic [31:0] o_addr_hold,
  input  logic        o_data_valid,
  output logic        o_data_ready,
  input  logic [7:0]  o_data_bits
);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, RSP = 2'd3} state_e;

  state_e      state_q, state_d;
  logic [31:0] cur_addr_q, cur_addr_d;
  logic [31:0] hold_q, hold_d;
  logic [2:0]  rem_q, rem_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] asm_q, asm_d;
  logic        err_q, err_d;
  logic        cmd_bad;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      hold_q     <= '0;
      rem_q      <= '0;
      lane_q     <= '0;
      asm_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      hold_q     <= hold_d;
      rem_q      <= rem_d;
      lane_q     <= lane_d;
      asm_q      <= asm_d;
      err_q      <= err_d;
    end
  end

  // Writes, size 3 and misaligned accesses are answered with an error and never reach flash.
  assign cmd_bad = !i_icb_cmd_read || (i_icb_cmd_size == 2'd3) ||
                   ((i_icb_cmd_size == 2'd1) && i_icb_cmd_addr[0]) ||
                   ((i_icb_cmd_size == 2'd2) && (i_icb_cmd_addr[1:0] != 2'd0));

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    hold_d     = hold_q;
    rem_d      = rem_q;
    lane_d     = lane_q;
    asm_d      = asm_q;
    err_d      = err_q;
    case (state_q)
      IDLE: if (i_icb_cmd_valid) begin
        asm_d = '0;
        if (cmd_bad) begin
          err_d   = 1'b1;
          state_d = RSP;
        end else begin
          err_d      = 1'b0;
          cur_addr_d = i_icb_cmd_addr & FLASH_ADDR_MASK;
          lane_d     = i_icb_cmd_addr[1:0];
          rem_d      = 3'd1 << i_icb_cmd_size;
          state_d    = ADDR;
        end
      end
      ADDR: if (o_addr_ready) begin
        hold_d  = cur_addr_q;
        state_d = DATA;
      end
      DATA: if (o_data_valid) begin
        asm_d[{lane_q, 3'b000} +: 8] = o_data_bits;
        lane_d     = lane_q + 2'd1;
        cur_addr_d = cur_addr_q + 32'd1;
        rem_d      = rem_q - 3'd1;
        state_d    = (rem_q == 3'd1) ? RSP : ADDR;
      end
      RSP: if (i_icb_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign i_icb_cmd_ready = (state_q == IDLE);
  assign o_addr_valid    = (state_q == ADDR);
  assign o_data_ready    = (state_q == DATA);
  assign i_icb_rsp_valid = (state_q == RSP);
  assign i_icb_rsp_rdata = i_icb_rsp_valid ? asm_q : 32'd0;
  assign i_icb_rsp_err   = i_icb_rsp_valid & err_q;
  assign o_addr_next     = cur_addr_q;
  assign o_addr_hold     = hold_q;

endmodule

// File: tb/tb_sirv_qspi_flash_fetch.sv
// Directed vector bench for sirv_qspi_flash_fetch: a table of ICB reads with a
// byte-returning flashmap model, plus reset and mid-transaction reset sequences.
module tb_sirv_qspi_flash_fetch;

  localparam logic [31:0] MASK = 32'h1FFF_FFFF;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_icb_cmd_valid, i_icb_cmd_ready;
  logic [31:0] i_icb_cmd_addr;
  logic        i_icb_cmd_read;
  logic [1:0]  i_icb_cmd_size;
  logic        i_icb_rsp_valid, i_icb_rsp_ready;
  logic [31:0] i_icb_rsp_rdata;
  logic        i_icb_rsp_err;
  logic        o_addr_valid, o_addr_ready;
  logic [31:0] o_addr_next, o_addr_hold;
  logic        o_data_valid, o_data_ready;
  logic [7:0]  o_data_bits;

  sirv_qspi_flash_fetch #(.FLASH_ADDR_MASK(MASK)) dut (
    .clock(clock), .reset(reset),
    .i_icb_cmd_valid(i_icb_cmd_valid), .i_icb_cmd_ready(i_icb_cmd_ready),
    .i_icb_cmd_addr(i_icb_cmd_addr), .i_icb_cmd_read(i_icb_cmd_read),
    .i_icb_cmd_size(i_icb_cmd_size),
    .i_icb_rsp_valid(i_icb_rsp_valid), .i_icb_rsp_ready(i_icb_rsp_ready),
    .i_icb_rsp_rdata(i_icb_rsp_rdata), .i_icb_rsp_err(i_icb_rsp_err),
    .o_addr_valid(o_addr_valid), .o_addr_ready(o_addr_ready),
    .o_addr_next(o_addr_next), .o_addr_hold(o_addr_hold),
    .o_data_valid(o_data_valid), .o_data_ready(o_data_ready),
    .o_data_bits(o_data_bits)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        rd;
    logic [1:0]  sz;
    logic [31:0] bytes;   // byte k returned for the k-th data handshake is bytes[8k+:8]
    int          astall, dstall, rstall;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_na;
  } vec_t;

  vec_t vt[9];
  int   nvec = 0;
  int   nfail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_icb_cmd_valid = 1'b0; i_icb_cmd_addr = '0; i_icb_cmd_read = 1'b0; i_icb_cmd_size = '0;
    i_icb_rsp_ready = 1'b0; o_addr_ready = 1'b0; o_data_valid = 1'b0; o_data_bits = '0;
  endtask

  // Issues one command, plays the flashmap with the vector's stall counts and
  // captures the response; seq_ok drops on any address/stability/ready violation.
  task automatic run_vec(input vec_t v, output logic [31:0] rd, output logic er,
                         output int lat, output int na, output bit seq_ok);
    int bi, as, ds, rs;
    logic [31:0] base;
    bit done;
    base = v.addr & MASK;
    seq_ok = 1'b1; na = 0; bi = 0; lat = -1; rd = '0; er = 1'b0;
    as = v.astall; ds = v.dstall; rs = v.rstall; done = 1'b0;
    @(negedge clock);
    if (i_icb_cmd_ready !== 1'b1) seq_ok = 1'b0;
    idle_inputs();
    i_icb_cmd_valid = 1'b1; i_icb_cmd_addr = v.addr;
    i_icb_cmd_read = v.rd; i_icb_cmd_size = v.sz;
    for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
      @(negedge clock);
      idle_inputs();
      if (i_icb_cmd_ready !== 1'b0) seq_ok = 1'b0;
      if (o_addr_valid) begin
        if (o_addr_next !== base + na) seq_ok = 1'b0;
        if (na > 0 && o_addr_hold !== base + na - 1) seq_ok = 1'b0;
        if (as > 0) as--;
        else begin o_addr_ready = 1'b1; na++; end
      end
      if (o_data_ready) begin
        if (ds > 0) ds--;
        else if (bi < 4) begin
          o_data_valid = 1'b1; o_data_bits = v.bytes[bi*8 +: 8]; bi++;
        end else seq_ok = 1'b0;
      end
      if (i_icb_rsp_valid) begin
        if (lat < 0) begin lat = cyc; rd = i_icb_rsp_rdata; er = i_icb_rsp_err; end
        else if (i_icb_rsp_rdata !== rd || i_icb_rsp_err !== er) seq_ok = 1'b0;
        if (rs > 0) rs--;
        else begin i_icb_rsp_ready = 1'b1; done = 1'b1; end
      end
    end
    if (!done) seq_ok = 1'b0;
  endtask

  task automatic check_vec(input vec_t v);
    logic [31:0] rd;
    logic er;
    int lat, na;
    bit ok;
    run_vec(v, rd, er, lat, na, ok);
    chk({v.name, " rdata"}, rd, v.exp_rdata);
    chk({v.name, " err"}, {31'd0, er}, {31'd0, v.exp_err});
    chk({v.name, " latency"}, lat, v.exp_lat);
    chk({v.name, " addr handshakes"}, na, v.exp_na);
    chk({v.name, " sequence ok"}, {31'd0, ok}, 32'd1);
  endtask

  function automatic vec_t mk(input string name, input logic [31:0] addr, input logic rd,
                              input logic [1:0] sz, input logic [31:0] bytes,
                              input int as, input int ds, input int rs,
                              input logic [31:0] exp_rdata, input logic exp_err,
                              input int exp_lat, input int exp_na);
    vec_t v;
    v.name = name; v.addr = addr; v.rd = rd; v.sz = sz; v.bytes = bytes;
    v.astall = as; v.dstall = ds; v.rstall = rs;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat; v.exp_na = exp_na;
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, " cmd_ready"}, {31'd0, i_icb_cmd_ready}, 32'd1);
    chk({tag, " addr_valid"}, {31'd0, o_addr_valid}, 32'd0);
    chk({tag, " data_ready"}, {31'd0, o_data_ready}, 32'd0);
    chk({tag, " rsp_valid"}, {31'd0, i_icb_rsp_valid}, 32'd0);
    chk({tag, " rdata"}, i_icb_rsp_rdata, 32'd0);
    chk({tag, " err"}, {31'd0, i_icb_rsp_err}, 32'd0);
    chk({tag, " addr_next"}, o_addr_next, 32'd0);
    chk({tag, " addr_hold"}, o_addr_hold, 32'd0);
  endtask

  initial begin
    //     name        addr          rd    sz    bytes         as ds rs  rdata         err  lat na
    vt[0] = mk("word",     32'h2000_0100, 1'b1, 2'd2, 32'h4433_2211, 0, 0, 0, 32'h4433_2211, 1'b0, 9, 4);
    vt[1] = mk("byte3",    32'h0000_0003, 1'b1, 2'd0, 32'h0000_00A5, 0, 0, 0, 32'hA500_0000, 1'b0, 3, 1);
    vt[2] = mk("write",    32'h0000_0100, 1'b0, 2'd2, 32'h0,         0, 0, 0, 32'h0,         1'b1, 1, 0);
    vt[3] = mk("mis_half", 32'h0000_0001, 1'b1, 2'd1, 32'h0,         0, 0, 0, 32'h0,         1'b1, 1, 0);
    vt[4] = mk("size3",    32'h0000_0000, 1'b1, 2'd3, 32'h0,         0, 0, 0, 32'h0,         1'b1, 1, 0);
    vt[5] = mk("half2",    32'h0000_0002, 1'b1, 2'd1, 32'h0000_C35A, 0, 0, 0, 32'hC35A_0000, 1'b0, 5, 2);
    vt[6] = mk("wrap",     32'hFFFF_FFFC, 1'b1, 2'd2, 32'h0403_0201, 0, 0, 0, 32'h0403_0201, 1'b0, 9, 4);
    vt[7] = mk("mask_b1",  32'hE000_0001, 1'b1, 2'd0, 32'h0000_007E, 0, 0, 0, 32'h0000_7E00, 1'b0, 3, 1);
    vt[8] = mk("bkpress",  32'h0000_0040, 1'b1, 2'd2, 32'hDDCC_BBAA, 3, 2, 4, 32'hDDCC_BBAA, 1'b0, 14, 4);

    idle_inputs();
    reset = 1'b1;
    #1;
    check_reset_outputs("in_reset");
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_reset_outputs("after_reset");

    // A stray data beat while idle must be ignored.
    o_data_valid = 1'b1; o_data_bits = 8'hFF;
    @(negedge clock);
    chk("stray data_ready", {31'd0, o_data_ready}, 32'd0);
    chk("stray addr_next", o_addr_next, 32'd0);
    idle_inputs();

    for (int i = 0; i < 9; i++) check_vec(vt[i]);

    // Reset while in DATA with two bytes of a word read still outstanding.
    @(negedge clock);
    idle_inputs();
    i_icb_cmd_valid = 1'b1; i_icb_cmd_addr = 32'h0000_0200;
    i_icb_cmd_read = 1'b1; i_icb_cmd_size = 2'd2;
    o_addr_ready = 1'b1; o_data_valid = 1'b1; o_data_bits = 8'h11;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      i_icb_cmd_valid = 1'b0;
    end
    chk("mid in DATA", {31'd0, o_data_ready}, 32'd1);
    chk("mid addr_next", o_addr_next, 32'h0000_0202);
    reset = 1'b1;
    idle_inputs();
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clock);
    reset = 1'b0;
    check_vec(mk("post_rst", 32'h0000_0010, 1'b1, 2'd1, 32'h0000_BC9A, 0, 0, 0,
                 32'h0000_BC9A, 1'b0, 5, 2));

    @(negedge clock);
    idle_inputs();
    chk("final cmd_ready", {31'd0, i_icb_cmd_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
